ps2_key_event: RTL and testbench

- Sits between the PS/2 byte receiver and the typing-game display/scoring logic.
- Turns the raw PS/2 Set-2 byte stream into one clean ASCII event per key press:
  - tracks the E0/F0 prefixes;
  - suppresses typematic repeats;
  - drops break codes;
  - buffers events in a small FIFO with a valid/ready handshake.
- Also exports the ASCII of the key currently held, as a level.

---
 rtl/kbd_pkg.sv | 70 +++++++
 rtl/ps2_key_event_if.sv | 23 ++
 rtl/kbd_event_fifo.sv | 61 ++++++
 rtl/ps2_key_event.sv | 124 ++++++++++++
 tb/tb_ps2_key_event.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, decoder state type and the Set-2 scan-code to ASCII map for ps2_key_event.
package kbd_pkg;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic       mapped;
        logic [7:0] ascii;
    } kbd_map_t;

    // Lowercase letters, digits, space and enter; everything else is unmapped.
    function automatic kbd_map_t scan_to_ascii(input logic [7:0] sc);
        kbd_map_t m;
        m.mapped = 1'b1;
        m.ascii  = 8'h00;
        case (sc)
            8'h1C: m.ascii = 8'h61;
            8'h32: m.ascii = 8'h62;
            8'h21: m.ascii = 8'h63;
            8'h23: m.ascii = 8'h64;
            8'h24: m.ascii = 8'h65;
            8'h2B: m.ascii = 8'h66;
            8'h34: m.ascii = 8'h67;
            8'h33: m.ascii = 8'h68;
            8'h43: m.ascii = 8'h69;
            8'h3B: m.ascii = 8'h6A;
            8'h42: m.ascii = 8'h6B;
            8'h4B: m.ascii = 8'h6C;
            8'h3A: m.ascii = 8'h6D;
            8'h31: m.ascii = 8'h6E;
            8'h44: m.ascii = 8'h6F;
            8'h4D: m.ascii = 8'h70;
            8'h15: m.ascii = 8'h71;
            8'h2D: m.ascii = 8'h72;
            8'h1B: m.ascii = 8'h73;
            8'h2C: m.ascii = 8'h74;
            8'h3C: m.ascii = 8'h75;
            8'h2A: m.ascii = 8'h76;
            8'h1D: m.ascii = 8'h77;
            8'h22: m.ascii = 8'h78;
            8'h35: m.ascii = 8'h79;
            8'h1A: m.ascii = 8'h7A;
            8'h45: m.ascii = 8'h30;
            8'h16: m.ascii = 8'h31;
            8'h1E: m.ascii = 8'h32;
            8'h26: m.ascii = 8'h33;
            8'h25: m.ascii = 8'h34;
            8'h2E: m.ascii = 8'h35;
            8'h36: m.ascii = 8'h36;
            8'h3D: m.ascii = 8'h37;
            8'h3E: m.ascii = 8'h38;
            8'h46: m.ascii = 8'h39;
            8'h29: m.ascii = 8'h20;
            8'h5A: m.ascii = 8'h0D;
            default: m.mapped = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_key_event_if.sv
// Byte-in / event-out bundle of ps2_key_event; slave is the decoder side, master the byte source/consumer.
interface ps2_key_event_if #(parameter int unsigned FIFO_DEPTH = 8);

    logic [7:0]                   ps2_byte;
    logic                         ps2_valid;
    logic [7:0]                   key_ascii;
    logic                         key_valid;
    logic                         key_ready;
    logic [7:0]                   held_ascii;
    logic                         overflow;
    logic [$clog2(FIFO_DEPTH):0]  fifo_level;

    modport slave (
        input  ps2_byte, ps2_valid, key_ready,
        output key_ascii, key_valid, held_ascii, overflow, fifo_level
    );

    modport master (
        output ps2_byte, ps2_valid, key_ready,
        input  key_ascii, key_valid, held_ascii, overflow, fifo_level
    );

endinterface

// File: rtl/kbd_event_fifo.sv
// Show-ahead event FIFO; a push into a full FIFO succeeds only when a pop happens in the same cycle.
module kbd_event_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             push_ok, pop_ok;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: head_o is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 Set-2 byte stream to one ASCII event per key press, with typematic filtering and an event FIFO.
// Optional SHIFT_UPPER_EN: shift keys uppercase letters pressed while held.
module ps2_key_event
    import kbd_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned REPEAT_FILTER = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    ps2_key_event_if.slave        bus
);

    kbd_state_e state_q, state_d;
    logic [7:0] held_code_q, held_code_d;
    logic [7:0] held_ascii_q, held_ascii_d;
    logic       overflow_q, overflow_d;
    logic       shift_q, shift_d;
    logic       push_c;
    logic [7:0] push_ascii_c;
    logic       pop_c;
    logic       fifo_full;
    logic       fifo_empty;
    kbd_map_t   map_c;
    logic       is_prefix_c;
    logic       is_shift_c;

    assign map_c       = scan_to_ascii(bus.ps2_byte);
    assign is_prefix_c = (bus.ps2_byte == SC_BREAK) || (bus.ps2_byte == SC_EXT);
`ifdef SHIFT_UPPER_EN
    assign is_shift_c  = (bus.ps2_byte == SC_LSHIFT) || (bus.ps2_byte == SC_RSHIFT);
`else
    assign is_shift_c  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.ps2_valid) begin
            case (state_q)
                IDLE: begin
                    if (bus.ps2_byte == SC_BREAK)    state_d = BRK;
                    else if (bus.ps2_byte == SC_EXT) state_d = EXT;
                end
                EXT:     state_d = (bus.ps2_byte == SC_BREAK) ? EXT_BRK : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Event generation and held-key tracking.
    always_comb begin
        push_c       = 1'b0;
        push_ascii_c = map_c.ascii;
        held_code_d  = held_code_q;
        held_ascii_d = held_ascii_q;
        shift_d      = shift_q;
        if (shift_q && map_c.ascii >= 8'h61 && map_c.ascii <= 8'h7A)
            push_ascii_c = map_c.ascii - 8'h20;
        if (bus.ps2_valid) begin
            case (state_q)
                IDLE: begin
                    if (is_shift_c) begin
                        shift_d = 1'b1;
                    end else if (!is_prefix_c && map_c.mapped &&
                                 !((REPEAT_FILTER != 0) && (bus.ps2_byte == held_code_q))) begin
                        push_c       = 1'b1;
                        held_code_d  = bus.ps2_byte;
                        held_ascii_d = push_ascii_c;
                    end
                end
                BRK: begin
                    if (is_shift_c) shift_d = 1'b0;
                    if (bus.ps2_byte == held_code_q) begin
                        held_code_d  = 8'h00;
                        held_ascii_d = 8'h00;
                    end
                end
                default: ;
            endcase
        end
        overflow_d = overflow_q || (push_c && fifo_full && !pop_c);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_code_q  <= 8'h00;
            held_ascii_q <= 8'h00;
            overflow_q   <= 1'b0;
            shift_q      <= 1'b0;
        end else begin
            held_code_q  <= held_code_d;
            held_ascii_q <= held_ascii_d;
            overflow_q   <= overflow_d;
            shift_q      <= shift_d;
        end
    end

    assign pop_c = !fifo_empty && bus.key_ready;

    kbd_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .data_i  (push_ascii_c),
        .pop_i   (pop_c),
        .head_o  (bus.key_ascii),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (bus.fifo_level)
    );

    assign bus.key_valid  = !fifo_empty;
    assign bus.held_ascii = held_ascii_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: a filtered DUT plus an unfiltered twin sharing the same stimulus.
module tb_ps2_key_event;
    import kbd_pkg::*;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ps2_key_event_if #(.FIFO_DEPTH(8)) bus ();
    ps2_key_event_if #(.FIFO_DEPTH(8)) bus0 ();

    ps2_key_event #(.FIFO_DEPTH(8), .REPEAT_FILTER(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ps2_key_event #(.FIFO_DEPTH(8), .REPEAT_FILTER(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    assign bus0.ps2_byte  = bus.ps2_byte;
    assign bus0.ps2_valid = bus.ps2_valid;
    assign bus0.key_ready = bus.key_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.ps2_byte  = b;
        bus.ps2_valid = 1'b1;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
    endtask

    task automatic pop1();
        @(negedge clk);
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.key_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic [7:0] ovf_bytes [9];
    logic [7:0] ovf_ascii [8];

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.ps2_byte  = 8'h00;
        bus.ps2_valid = 1'b0;
        bus.key_ready = 1'b0;
        ovf_bytes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        ovf_ascii = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74, 8'h79, 8'h75, 8'h69};

        // Reset with a make strobed in the same cycle: byte must be discarded.
        @(negedge clk);
        bus.ps2_byte  = 8'h1C;
        bus.ps2_valid = 1'b1;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
        reset = 1'b0;
        chk("rst_key_ascii", 32'(bus.key_ascii), 32'h00);
        chk("rst_key_valid", 32'(bus.key_valid), 32'h0);
        chk("rst_held", 32'(bus.held_ascii), 32'h00);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        chk("rst_level", 32'(bus.fifo_level), 32'h0);

        // Press / release of 'a'.
        send(8'h1C);
        chk("press_valid", 32'(bus.key_valid), 32'h1);
        chk("press_ascii", 32'(bus.key_ascii), 32'h61);
        chk("press_held", 32'(bus.held_ascii), 32'h61);
        send(8'hF0);
        send(8'h1C);
        chk("release_held", 32'(bus.held_ascii), 32'h00);
        chk("release_level", 32'(bus.fifo_level), 32'h1);
        pop1();
        chk("pop_valid", 32'(bus.key_valid), 32'h0);
        chk("pop_ascii", 32'(bus.key_ascii), 32'h00);

        // Typematic repeat: filtered DUT gives 1 event, unfiltered twin gives 3.
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        chk("repeat_held", 32'(bus.held_ascii), 32'h61);
        send(8'hF0);
        send(8'h1C);
        chk("repeat_level_f1", 32'(bus.fifo_level), 32'h1);
        chk("repeat_level_f0", 32'(bus0.fifo_level), 32'h3);
        chk("repeat_held_clr", 32'(bus.held_ascii), 32'h00);
        pop1();
        pop1();
        pop1();
        chk("repeat_drain_f1", 32'(bus.fifo_level), 32'h0);
        chk("repeat_drain_f0", 32'(bus0.fifo_level), 32'h0);

        // Extended and unmapped codes produce nothing; decoder returns to IDLE.
        send(8'hE0);
        send(8'h75);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'h05);
        chk("ext_level", 32'(bus.fifo_level), 32'h0);
        chk("ext_held", 32'(bus.held_ascii), 32'h00);
        send(8'h1C);
        chk("ext_idle_ascii", 32'(bus.key_ascii), 32'h61);
        chk("ext_idle_level", 32'(bus.fifo_level), 32'h1);
        pop1();

        // Overflow: nine makes into an 8-deep FIFO with no consumer.
        for (int i = 0; i < 9; i++) send(ovf_bytes[i]);
        chk("ovf_level", 32'(bus.fifo_level), 32'h8);
        chk("ovf_flag", 32'(bus.overflow), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_drain%0d", i), 32'(bus.key_ascii), 32'(ovf_ascii[i]));
            pop1();
        end
        chk("ovf_empty", 32'(bus.key_valid), 32'h0);
        chk("ovf_sticky", 32'(bus.overflow), 32'h1);

        // Full FIFO with simultaneous push and pop.
        pulse_reset();
        chk("rst2_overflow", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < 8; i++) send(ovf_bytes[i]);
        chk("full_level", 32'(bus.fifo_level), 32'h8);
        @(negedge clk);
        bus.ps2_byte  = 8'h4D;
        bus.ps2_valid = 1'b1;
        bus.key_ready = 1'b1;
        @(negedge clk);
        bus.ps2_valid = 1'b0;
        bus.key_ready = 1'b0;
        chk("pp_level", 32'(bus.fifo_level), 32'h8);
        chk("pp_overflow", 32'(bus.overflow), 32'h0);
        chk("pp_head", 32'(bus.key_ascii), 32'h77);
        for (int i = 0; i < 7; i++) pop1();
        chk("pp_tail", 32'(bus.key_ascii), 32'h70);
        chk("pp_tail_level", 32'(bus.fifo_level), 32'h1);

        // Reset between a break prefix and its code forgets the prefix.
        send(8'hF0);
        pulse_reset();
        chk("mid_rst_level", 32'(bus.fifo_level), 32'h0);
        send(8'h1C);
        chk("mid_rst_valid", 32'(bus.key_valid), 32'h1);
        chk("mid_rst_ascii", 32'(bus.key_ascii), 32'h61);
        chk("mid_rst_held", 32'(bus.held_ascii), 32'h61);

`ifdef SHIFT_UPPER_EN
        send(8'hF0);
        send(8'h1C);
        pop1();
        send(SC_LSHIFT);
        chk("shift_no_event", 32'(bus.fifo_level), 32'h0);
        send(8'h1C);
        chk("shift_upper", 32'(bus.key_ascii), 32'h41);
        chk("shift_held", 32'(bus.held_ascii), 32'h41);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
